// File: rtl/ifetch_unit.sv
// Instruction fetch front end: issues sequential word fetches under a credit
// limit, buffers in-order responses in a small FIFO and hands them to decode.
// A redirect flushes the FIFO and discards responses still in flight.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  instr_op,
  output logic [5:0]  instr_funct
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, rsp_pc;
  logic [CW-1:0] count, outstanding, drop_cnt;
  logic [CW-1:0] count_next, outstanding_next, drop_next;
  logic [PW-1:0] head, tail;
  logic [31:0]   word_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [CW:0]   credits_used;
  logic          req_fire, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_C) return '0;
    return p + PW'(1);
  endfunction

  // Both buffered words and requests still in flight consume a credit, so a
  // response always finds a free slot.
  assign credits_used   = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !reset && !redirect_valid && (credits_used < DEPTH_C);
  assign imem_addr      = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses are kept only once all stale ones from before a redirect are gone.
  assign push        = imem_rsp_valid && !redirect_valid && (state == FETCH);
  assign instr_valid = !reset && !redirect_valid && (count != '0);
  assign pop         = instr_valid && instr_ready;

  assign instr       = word_mem[head];
  assign instr_pc    = pc_mem[head];
  assign instr_op    = instr[31:26];
  assign instr_funct = instr[5:0];

  // Next-state for the counters and the FETCH/DRAIN machine; redirect wins.
  always_comb begin
    count_next       = count;
    outstanding_next = outstanding;
    drop_next        = drop_cnt;
    state_next       = state;
    if (redirect_valid) begin
      count_next       = '0;
      outstanding_next = outstanding - CW'(imem_rsp_valid);
      drop_next        = outstanding - CW'(imem_rsp_valid);
      state_next       = (drop_next != '0) ? DRAIN : FETCH;
    end else begin
      outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      count_next       = count + CW'(push) - CW'(pop);
      if (imem_rsp_valid && (drop_cnt != '0)) begin
        drop_next = drop_cnt - CW'(1);
      end
      if ((state == DRAIN) && (drop_next == '0)) begin
        state_next = FETCH;
      end
    end
  end

  // Control state: PCs, counters, FIFO pointers and the FSM register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          tail   <= ptr_inc(tail);
        end
        if (pop) begin
          head <= ptr_inc(head);
        end
      end
    end
  end

  // FIFO storage holds each kept word alongside the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      word_mem[tail] <= imem_rsp_data;
      pc_mem[tail]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a per-cycle vector table for streaming and
// back-pressure, then hand sequences for redirects, PC wrap and reset.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, instr_ready = 1'b1;
  logic [31:0] instr, instr_pc;
  logic [5:0]  instr_op, instr_funct;

  logic        req_valid_w;
  logic [31:0] addr_w;
  logic        rsp_valid_w = 1'b0;
  logic [31:0] rsp_data_w = '0;
  logic        instr_valid_w;
  logic [31:0] instr_w, instr_pc_w;
  logic [5:0]  op_w, funct_w;

  int          checks = 0;
  int          errors = 0;
  bit          rsp_en = 1'b1;
  logic [31:0] pend[$];

  ifetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .instr_op(instr_op), .instr_funct(instr_funct)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(req_valid_w), .imem_req_ready(1'b1), .imem_addr(addr_w),
    .imem_rsp_valid(rsp_valid_w), .imem_rsp_data(rsp_data_w),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(instr_valid_w), .instr_ready(1'b1), .instr(instr_w), .instr_pc(instr_pc_w),
    .instr_op(op_w), .instr_funct(funct_w)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // A push into a full buffer with no pop would lose data
  always @(negedge clk) begin
    if (!reset && dut.push && !dut.pop && (dut.count == 2'd2)) begin
      errors++;
      $display("[TB] FAIL overflow: push into full buffer at time %0t", $time);
    end
  end

  typedef struct {
    bit          rst;
    bit          ir;
    bit          exp_rv;
    logic [31:0] exp_addr;
    bit          exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[19];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic driveRsp();
    imem_rsp_valid = rsp_en && (pend.size() != 0);
    imem_rsp_data  = (pend.size() != 0) ? ~pend[0] : 32'h0;
  endtask

  // One clock: the memory model records accepted requests and answers one cycle later
  task automatic tick();
    bit          fire, rv, rst, fire_w;
    logic [31:0] a, a_w;
    @(negedge clk);
    fire   = imem_req_valid && imem_req_ready;
    rv     = imem_rsp_valid;
    rst    = reset;
    a      = imem_addr;
    fire_w = req_valid_w;
    a_w    = addr_w;
    @(posedge clk);
    #1;
    if (rst) begin
      pend.delete();
    end else begin
      if (rv) void'(pend.pop_front());
      if (fire) pend.push_back(a);
    end
    rsp_valid_w = fire_w && !rst;
    rsp_data_w  = ~a_w;
    driveRsp();
  endtask

  task automatic applyStimulus(input vec_t v);
    reset          = v.rst;
    instr_ready    = v.ir;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic checkInstr(input string name, input logic [31:0] pc);
    logic [31:0] w;
    w = ~pc;
    checkOutput({name, " valid"}, {31'b0, instr_valid}, 32'd1);
    checkOutput({name, " pc"}, instr_pc, pc);
    checkOutput({name, " instr"}, instr, w);
    checkOutput({name, " op"}, {26'b0, instr_op}, {26'b0, w[31:26]});
    checkOutput({name, " funct"}, {26'b0, instr_funct}, {26'b0, w[5:0]});
  endtask

  task automatic waitInstr(input string name, input logic [31:0] pc);
    for (int i = 0; i < 20 && !instr_valid; i++) tick();
    if (!instr_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got no instr_valid expected pc %h", name, pc);
    end else begin
      checkInstr(name, pc);
    end
  endtask

  task automatic doReset();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    rsp_en         = 1'b1;
    driveRsp();
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // streaming with decode always ready
    vecs[0]  = '{1, 1, 0, 32'h00, 0, 32'h00};
    vecs[1]  = '{0, 1, 1, 32'h00, 0, 32'h00};
    vecs[2]  = '{0, 1, 1, 32'h04, 0, 32'h00};
    vecs[3]  = '{0, 1, 0, 32'h00, 1, 32'h00};
    vecs[4]  = '{0, 1, 1, 32'h08, 1, 32'h04};
    vecs[5]  = '{0, 1, 1, 32'h0C, 0, 32'h00};
    vecs[6]  = '{0, 1, 0, 32'h00, 1, 32'h08};
    vecs[7]  = '{0, 1, 1, 32'h10, 1, 32'h0C};
    vecs[8]  = '{0, 1, 1, 32'h14, 0, 32'h00};
    // stalled decode fills the buffer, then releases it
    vecs[9]  = '{1, 0, 0, 32'h00, 0, 32'h00};
    vecs[10] = '{0, 0, 1, 32'h00, 0, 32'h00};
    vecs[11] = '{0, 0, 1, 32'h04, 0, 32'h00};
    vecs[12] = '{0, 0, 0, 32'h00, 1, 32'h00};
    vecs[13] = '{0, 0, 0, 32'h00, 1, 32'h00};
    vecs[14] = '{0, 0, 0, 32'h00, 1, 32'h00};
    vecs[15] = '{0, 1, 0, 32'h00, 1, 32'h00};
    vecs[16] = '{0, 1, 1, 32'h08, 1, 32'h04};
    vecs[17] = '{0, 1, 1, 32'h0C, 0, 32'h00};
    vecs[18] = '{0, 1, 0, 32'h00, 1, 32'h08};

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].exp_rv});
      if (vecs[i].exp_rv) checkOutput($sformatf("vec%0d addr", i), imem_addr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].exp_iv});
      if (vecs[i].exp_iv) checkInstr($sformatf("vec%0d", i), vecs[i].exp_pc);
      tick();
    end

    // redirect with two requests in flight (0x8, 0xC): both dropped
    doReset();
    rsp_en = 1'b0;
    driveRsp();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    #1;
    checkOutput("t3 no req on redirect", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    checkOutput("t3 addr 8", imem_addr, 32'h8);
    tick();
    checkOutput("t3 addr C", imem_addr, 32'hC);
    tick();
    checkOutput("t3 credit full", {31'b0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    checkOutput("t3 instr_valid on redirect", {31'b0, instr_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    rsp_en = 1'b1;
    driveRsp();
    #1;
    checkOutput("t3 drop_cnt", {30'b0, dut.drop_cnt}, 32'd2);
    checkOutput("t3 drain credit", {31'b0, imem_req_valid}, 32'd0);
    waitInstr("t3 first", 32'h40);
    tick();
    waitInstr("t3 second", 32'h44);

    // redirect coincident with the response for 0x10, one more outstanding
    doReset();
    rsp_en = 1'b0;
    driveRsp();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    #1;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    rsp_en = 1'b1;
    driveRsp();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    #1;
    checkOutput("t4 instr_valid on redirect", {31'b0, instr_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    checkOutput("t4 drop_cnt", {30'b0, dut.drop_cnt}, 32'd1);
    checkOutput("t4 drain issue", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("t4 drain addr", imem_addr, 32'h80);
    waitInstr("t4 first", 32'h80);

    // reset with the buffer full
    doReset();
    instr_ready = 1'b0;
    #1;
    repeat (5) tick();
    checkOutput("t6 full valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("t6 full pc", instr_pc, 32'h0);
    checkOutput("t6 full no req", {31'b0, imem_req_valid}, 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("t6 req during reset", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("t6 valid during reset", {31'b0, instr_valid}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("t6 valid after reset", {31'b0, instr_valid}, 32'd0);
    checkOutput("t6 addr after reset", imem_addr, 32'h0);
    checkOutput("t6 req after reset", {31'b0, imem_req_valid}, 32'd1);
    instr_ready = 1'b1;
    waitInstr("t6 first", 32'h0);

    // PC wrap from 0xFFFFFFFC on the second instance
    doReset();
    checkOutput("t5 req0", {31'b0, req_valid_w}, 32'd1);
    checkOutput("t5 addr0", addr_w, 32'hFFFF_FFFC);
    tick();
    checkOutput("t5 req1", {31'b0, req_valid_w}, 32'd1);
    checkOutput("t5 addr1", addr_w, 32'h0);
    tick();
    checkOutput("t5 valid0", {31'b0, instr_valid_w}, 32'd1);
    checkOutput("t5 pc0", instr_pc_w, 32'hFFFF_FFFC);
    tick();
    checkOutput("t5 valid1", {31'b0, instr_valid_w}, 32'd1);
    checkOutput("t5 pc1", instr_pc_w, 32'h0);
    checkOutput("t5 instr1", instr_w, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
